// File: rtl/deal_sequencer.sv
// deal_sequencer
//   Control FSM for the baccarat engine. Steps one state per slow_clock edge,
//   strobes the six card-load lines into the card datapath in deal order,
//   applies the tableau (naturals, player third-card rule, banker third-card
//   rule) to the datapath's score feedback, and latches the win lights.
//
// Ports
//   slow_clock        in   step clock, all state changes on posedge
//   resetb            in   synchronous active-low reset
//   pscore_out[3:0]   in   player hand score 0..9 from the datapath
//   dscore_out[3:0]   in   dealer hand score 0..9 from the datapath
//   pcard3_out[3:0]   in   player third card rank (0 none, 11..13 J/Q/K)
//   load_pcard1..3    out  load dealt card into player slot n on next posedge
//   load_dcard1..3    out  load dealt card into dealer slot n on next posedge
//   player_win_light  out  player won or tie
//   dealer_win_light  out  dealer won or tie
//   state_out[3:0]    out  current state encoding (debug)
//
// Load strobes have no handshake: a strobe is high for exactly one cycle and
// the datapath unconditionally captures on the posedge that ends that cycle.

module deal_sequencer #(
    parameter int NATURAL_MIN = 8,
    parameter int PLAYER_DRAW = 5,
    parameter int BANKER_DRAW = 5
) (
    input  logic       slow_clock,
    input  logic       resetb,
    input  logic [3:0] pscore_out,
    input  logic [3:0] dscore_out,
    input  logic [3:0] pcard3_out,
    output logic       load_pcard1,
    output logic       load_pcard2,
    output logic       load_pcard3,
    output logic       load_dcard1,
    output logic       load_dcard2,
    output logic       load_dcard3,
    output logic       player_win_light,
    output logic       dealer_win_light,
    output logic [3:0] state_out
);

    localparam logic [3:0] NAT_MIN  = 4'(NATURAL_MIN);
    localparam logic [3:0] P_DRAW   = 4'(PLAYER_DRAW);
    localparam logic [3:0] B_DRAW   = 4'(BANKER_DRAW);

    typedef enum logic [3:0] {
        S_P1   = 4'd0,
        S_D1   = 4'd1,
        S_P2   = 4'd2,
        S_D2   = 4'd3,
        S_EVAL = 4'd4,
        S_P3   = 4'd5,
        S_BANK = 4'd6,
        S_D3   = 4'd7,
        S_DONE = 4'd8
    } state_t;

    state_t state, next_state;

    // Set while the dealer's third card is being captured: on the edge that
    // enters S_DONE from S_D3 the datapath has not yet folded that card into
    // dscore_out, so the lights are latched one edge later from settled scores.
    logic lights_pending;

    logic [3:0] p3_value;
    logic       banker_draws;
    logic       natural;

    // Face cards and tens count zero.
    assign p3_value = (pcard3_out >= 4'd10) ? 4'd0 : pcard3_out;

    // Out-of-contract scores (>9) also satisfy >= NAT_MIN and end the deal.
    assign natural = (pscore_out >= NAT_MIN) || (dscore_out >= NAT_MIN);

    always_comb begin
        banker_draws = 1'b0;
        case (dscore_out)
            4'd0, 4'd1, 4'd2: banker_draws = 1'b1;
            4'd3:             banker_draws = (p3_value != 4'd8);
            4'd4:             banker_draws = (p3_value >= 4'd2) && (p3_value <= 4'd7);
            4'd5:             banker_draws = (p3_value >= 4'd4) && (p3_value <= 4'd7);
            4'd6:             banker_draws = (p3_value >= 4'd6) && (p3_value <= 4'd7);
            default:          banker_draws = 1'b0;
        endcase
    end

    always_ff @(posedge slow_clock) begin
        if (!resetb) begin
            state            <= S_P1;
            player_win_light <= 1'b0;
            dealer_win_light <= 1'b0;
            lights_pending   <= 1'b0;
        end else begin
            state <= next_state;
            if ((next_state == S_DONE) && ((state == S_EVAL) || (state == S_BANK))) begin
                player_win_light <= (pscore_out >= dscore_out);
                dealer_win_light <= (dscore_out >= pscore_out);
            end
            if (state == S_D3) begin
                lights_pending <= 1'b1;
            end
            if ((state == S_DONE) && lights_pending) begin
                player_win_light <= (pscore_out >= dscore_out);
                dealer_win_light <= (dscore_out >= pscore_out);
                lights_pending   <= 1'b0;
            end
        end
    end

    always_comb begin
        next_state  = state;
        load_pcard1 = 1'b0;
        load_pcard2 = 1'b0;
        load_pcard3 = 1'b0;
        load_dcard1 = 1'b0;
        load_dcard2 = 1'b0;
        load_dcard3 = 1'b0;
        case (state)
            S_P1: begin
                load_pcard1 = 1'b1;
                next_state  = S_D1;
            end
            S_D1: begin
                load_dcard1 = 1'b1;
                next_state  = S_P2;
            end
            S_P2: begin
                load_pcard2 = 1'b1;
                next_state  = S_D2;
            end
            S_D2: begin
                load_dcard2 = 1'b1;
                next_state  = S_EVAL;
            end
            S_EVAL: begin
                if (natural)                 next_state = S_DONE;
                else if (pscore_out <= P_DRAW) next_state = S_P3;
                else if (dscore_out <= B_DRAW) next_state = S_D3;
                else                         next_state = S_DONE;
            end
            S_P3: begin
                load_pcard3 = 1'b1;
                next_state  = S_BANK;
            end
            S_BANK: begin
                next_state = banker_draws ? S_D3 : S_DONE;
            end
            S_D3: begin
                load_dcard3 = 1'b1;
                next_state  = S_DONE;
            end
            S_DONE: begin
                next_state = S_DONE;
            end
            default: begin
                next_state = S_P1;
            end
        endcase
        // The datapath clears during reset; no card may be captured then.
        if (!resetb) begin
            load_pcard1 = 1'b0;
            load_pcard2 = 1'b0;
            load_pcard3 = 1'b0;
            load_dcard1 = 1'b0;
            load_dcard2 = 1'b0;
            load_dcard3 = 1'b0;
        end
    end

    assign state_out = state;

endmodule

// File: tb/tb_deal_sequencer.sv
module tb_deal_sequencer;

    localparam logic [3:0] S_P1   = 4'd0;
    localparam logic [3:0] S_D1   = 4'd1;
    localparam logic [3:0] S_P2   = 4'd2;
    localparam logic [3:0] S_D2   = 4'd3;
    localparam logic [3:0] S_EVAL = 4'd4;
    localparam logic [3:0] S_P3   = 4'd5;
    localparam logic [3:0] S_BANK = 4'd6;
    localparam logic [3:0] S_D3   = 4'd7;
    localparam logic [3:0] S_DONE = 4'd8;

    // Load bit order in the observed vector: {d3,d2,d1,p3,p2,p1}
    localparam logic [5:0] L_P1 = 6'b000001;
    localparam logic [5:0] L_P2 = 6'b000010;
    localparam logic [5:0] L_P3 = 6'b000100;
    localparam logic [5:0] L_D1 = 6'b001000;
    localparam logic [5:0] L_D2 = 6'b010000;
    localparam logic [5:0] L_D3 = 6'b100000;
    localparam logic [5:0] L_NONE = 6'b000000;

    // ---------------- clock / reset ----------------
    logic slow_clock = 1'b0;
    logic resetb     = 1'b0;
    always #5 slow_clock = ~slow_clock;

    logic [3:0] pscore_out, dscore_out, pcard3_out;
    logic load_pcard1, load_pcard2, load_pcard3;
    logic load_dcard1, load_dcard2, load_dcard3;
    logic player_win_light, dealer_win_light;
    logic [3:0] state_out;

    deal_sequencer dut (
        .slow_clock       (slow_clock),
        .resetb           (resetb),
        .pscore_out       (pscore_out),
        .dscore_out       (dscore_out),
        .pcard3_out       (pcard3_out),
        .load_pcard1      (load_pcard1),
        .load_pcard2      (load_pcard2),
        .load_pcard3      (load_pcard3),
        .load_dcard1      (load_dcard1),
        .load_dcard2      (load_dcard2),
        .load_dcard3      (load_dcard3),
        .player_win_light (player_win_light),
        .dealer_win_light (dealer_win_light),
        .state_out        (state_out)
    );

    // ---------------- card datapath stand-in ----------------
    // shoe order: p1, d1, p2, d2, p3, d3
    int shoe [6];
    logic [3:0] pc1, pc2, pc3, dc1, dc2, dc3;

    always @(posedge slow_clock) begin
        if (!resetb) begin
            pc1 <= 4'd0; pc2 <= 4'd0; pc3 <= 4'd0;
            dc1 <= 4'd0; dc2 <= 4'd0; dc3 <= 4'd0;
        end else begin
            if (load_pcard1) pc1 <= 4'(shoe[0]);
            if (load_dcard1) dc1 <= 4'(shoe[1]);
            if (load_pcard2) pc2 <= 4'(shoe[2]);
            if (load_dcard2) dc2 <= 4'(shoe[3]);
            if (load_pcard3) pc3 <= 4'(shoe[4]);
            if (load_dcard3) dc3 <= 4'(shoe[5]);
        end
    end

    function automatic int val(input int rank);
        return (rank >= 10) ? 0 : rank;
    endfunction

    always_comb begin
        pscore_out = 4'((val(int'(pc1)) + val(int'(pc2)) + val(int'(pc3))) % 10);
        dscore_out = 4'((val(int'(dc1)) + val(int'(dc2)) + val(int'(dc3))) % 10);
        pcard3_out = pc3;
    end

    // ---------------- scoreboard ----------------
    logic [9:0] exp_q[$];
    logic [1:0] exp_lights;
    int vectors = 0;
    int miscompares = 0;

    logic [9:0] obs;
    assign obs = {state_out, load_dcard3, load_dcard2, load_dcard1,
                  load_pcard3, load_pcard2, load_pcard1};

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    // Tableau written as a minimum third-card value per banker score.
    function automatic bit banker_ref(input int d, input int v);
        int lo [7];
        lo = '{0, 0, 0, 0, 2, 4, 6};
        if (d <= 2) return 1'b1;
        if (d == 3) return v != 8;
        if (d <= 6) return (v >= lo[d]) && (v <= 7);
        return 1'b0;
    endfunction

    task automatic build_expected();
        int p, d;
        bit pdraw, ddraw;
        p = (val(shoe[0]) + val(shoe[2])) % 10;
        d = (val(shoe[1]) + val(shoe[3])) % 10;
        pdraw = 1'b0;
        ddraw = 1'b0;
        if (p < 8 && d < 8) begin
            if (p <= 5) begin
                pdraw = 1'b1;
                ddraw = banker_ref(d, val(shoe[4]));
            end else begin
                ddraw = (d <= 5);
            end
        end
        exp_q.push_back({S_P1, L_P1});
        exp_q.push_back({S_D1, L_D1});
        exp_q.push_back({S_P2, L_P2});
        exp_q.push_back({S_D2, L_D2});
        exp_q.push_back({S_EVAL, L_NONE});
        if (pdraw) begin
            exp_q.push_back({S_P3, L_P3});
            exp_q.push_back({S_BANK, L_NONE});
        end
        if (ddraw) exp_q.push_back({S_D3, L_D3});
        repeat (3) exp_q.push_back({S_DONE, L_NONE});
        if (pdraw) p = (p + val(shoe[4])) % 10;
        if (ddraw) d = (d + val(shoe[5])) % 10;
        exp_lights = {p >= d, d >= p};
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge slow_clock);
        resetb = 1'b0;
        @(negedge slow_clock);
        check("rst_state_loads", 16'(obs), 16'({S_P1, L_NONE}));
        check("rst_lights", 16'({player_win_light, dealer_win_light}), 16'd0);
        resetb = 1'b1;
        #1;
    endtask

    task automatic run_cycles(input int n);
        logic [9:0] want;
        for (int i = 0; i < n; i++) begin
            if (exp_q.size() == 0) begin
                check("queue_underrun", 16'd1, 16'd0);
                return;
            end
            want = exp_q.pop_front();
            check("step", 16'(obs), 16'(want));
            @(negedge slow_clock);
        end
    endtask

    task automatic play_deal(input int c0, c1, c2, c3, c4, c5);
        shoe = '{c0, c1, c2, c3, c4, c5};
        do_reset();
        build_expected();
        run_cycles(exp_q.size());
        check("lights", 16'({player_win_light, dealer_win_light}), 16'(exp_lights));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        // 1 natural 9 vs 7
        play_deal(4, 3, 5, 4, 9, 9);
        // 2 player draws 7, banker on 6 draws
        play_deal(2, 13, 3, 6, 7, 2);
        // 3 player stands on 7, banker on 5 draws, tie
        play_deal(3, 2, 4, 3, 9, 2);
        // 4 banker on 3 stands against an 8
        play_deal(1, 12, 2, 3, 8, 9);
        // 5 face third card, banker on 4 stands
        play_deal(5, 4, 13, 13, 11, 9);
        // both stand: 6 vs 7
        play_deal(3, 4, 3, 3, 9, 9);

        // 6 reset while in S_P3, then replay a full deal
        shoe = '{2, 13, 3, 6, 7, 2};
        do_reset();
        build_expected();
        run_cycles(5);
        check("pre_reset_state", 16'(obs), 16'({S_P3, L_P3}));
        resetb = 1'b0;
        #1;
        check("reset_gates_loads", 16'(obs), 16'({S_P3, L_NONE}));
        exp_q.delete();
        @(negedge slow_clock);
        check("midreset_state", 16'(obs), 16'({S_P1, L_NONE}));
        check("midreset_lights", 16'({player_win_light, dealer_win_light}), 16'd0);
        resetb = 1'b1;
        #1;
        build_expected();
        run_cycles(exp_q.size());
        check("replay_lights", 16'({player_win_light, dealer_win_light}), 16'(exp_lights));

        // random shoes
        for (int k = 0; k < 40; k++) begin
            play_deal($urandom_range(1, 13), $urandom_range(1, 13), $urandom_range(1, 13),
                      $urandom_range(1, 13), $urandom_range(1, 13), $urandom_range(1, 13));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
